// File: rtl/isp_dram_pkg.sv
// isp_dram_pkg: shared types and constants for the ISP <-> pseudo_DRAM AXI4 sequencer.
// Contents: FSM state encoding, fixed AXI burst attributes and the picture memory map.
package isp_dram_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_AR = 3'd1,
    RD_R  = 3'd2,
    WR_AW = 3'd3,
    WR_W  = 3'd4,
    WR_B  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Every beat is a full 128-bit word; every burst is 64 incrementing beats.
  localparam logic [2:0]  SIZE_16B   = 3'b100;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [7:0]  LEN_64     = 8'd63;

  // Pictures are packed back to back starting at BASE_ADDR.
  localparam int          PIC_BYTES  = 3072;
  localparam logic [31:0] BASE_ADDR  = 32'h0001_0000;

endpackage

// File: rtl/isp_dram_ctrl_addr_gen.sv
// isp_dram_addr_gen: registered DRAM byte address of one burst of one picture.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_load             capture a new address this cycle
//   i_pic_no [3:0]     picture index
//   i_burst  [1:0]     burst index within the picture
//   o_addr   [31:0]    registered burst start address
module isp_dram_addr_gen #(
  parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
  parameter int          PIC_BYTES      = 3072,
  parameter int          BURSTS_PER_PIC = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [3:0]  i_pic_no,
  input  logic [1:0]  i_burst,
  output logic [31:0] o_addr
);

  // A picture is three 1 KB bursts, so pic*PIC_BYTES = (pic<<11) + (pic<<10)
  // and burst*1024 = burst<<10; no multiplier is needed.
  localparam int BURST_SH = $clog2(PIC_BYTES / BURSTS_PER_PIC);
  localparam int PIC_SH   = BURST_SH + 1;

  logic [31:0] w_pic;
  logic [31:0] w_burst;
  logic [31:0] w_addr;
  logic [31:0] r_addr;

  assign w_pic   = {28'd0, i_pic_no};
  assign w_burst = {30'd0, i_burst};
  assign w_addr  = BASE_ADDR + (w_pic << PIC_SH) + (w_pic << BURST_SH) + (w_burst << BURST_SH);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr <= 32'd0;
    end else if (i_load) begin
      r_addr <= w_addr;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/isp_dram_ctrl.sv
// isp_dram_ctrl: AXI4 master sequencer that moves one 32x32x3 picture (192 beats
// of 128 bits) between the ISP core and pseudo_DRAM as three 64-beat INCR bursts.
// Ports:
//   clk, rst_n                     clock, asynchronous reset (active-high despite the name)
//   req_valid/req_ready/req_write  picture request handshake and direction (1 = write)
//   req_pic_no [3:0]               picture index
//   rd_valid/rd_ready/rd_data      read beats towards the ISP datapath, rd_idx = beat 0..191
//   wr_req/wr_valid/wr_data        write beats pulled from the ISP datapath, wr_idx = beat 0..191
//   done, err                      one-cycle completion pulse, err = any nonzero rresp/bresp
//   ar*/r*/aw*/w*/b* _s_inf        AXI4 master channels towards pseudo_DRAM
module isp_dram_ctrl #(
  parameter logic [31:0] BASE_ADDR       = isp_dram_pkg::BASE_ADDR,
  parameter int          PIC_BYTES       = isp_dram_pkg::PIC_BYTES,
  parameter int          BEATS_PER_BURST = int'(isp_dram_pkg::LEN_64) + 1,
  parameter int          BURSTS_PER_PIC  = 3,
  parameter logic [3:0]  AXI_ID          = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [3:0]   req_pic_no,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [127:0] rd_data,
  output logic [7:0]   rd_idx,
  output logic         wr_req,
  input  logic         wr_valid,
  input  logic [127:0] wr_data,
  output logic [7:0]   wr_idx,
  output logic         done,
  output logic         err,
  output logic [3:0]   arid_s_inf,
  output logic [31:0]  araddr_s_inf,
  output logic [7:0]   arlen_s_inf,
  output logic [2:0]   arsize_s_inf,
  output logic [1:0]   arburst_s_inf,
  output logic         arvalid_s_inf,
  input  logic         arready_s_inf,
  input  logic [127:0] rdata_s_inf,
  input  logic [1:0]   rresp_s_inf,
  input  logic         rlast_s_inf,
  input  logic         rvalid_s_inf,
  output logic         rready_s_inf,
  output logic [3:0]   awid_s_inf,
  output logic [31:0]  awaddr_s_inf,
  output logic [7:0]   awlen_s_inf,
  output logic [2:0]   awsize_s_inf,
  output logic [1:0]   awburst_s_inf,
  output logic         awvalid_s_inf,
  input  logic         awready_s_inf,
  output logic [127:0] wdata_s_inf,
  output logic         wlast_s_inf,
  output logic         wvalid_s_inf,
  input  logic         wready_s_inf,
  input  logic [1:0]   bresp_s_inf,
  input  logic         bvalid_s_inf,
  output logic         bready_s_inf
);
  import isp_dram_pkg::*;

  localparam logic [5:0] LAST_BEAT  = 6'(BEATS_PER_BURST - 1);
  localparam logic [1:0] LAST_BURST = 2'(BURSTS_PER_PIC - 1);

  state_t      r_state;
  logic [3:0]  r_pic_no;
  logic [1:0]  r_burst_cnt;
  logic [5:0]  r_beat_cnt;
  logic        r_err_acc;
  logic [31:0] r_addr;

  logic        w_accept;
  logic        w_rd_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_last_burst;
  logic        w_next_burst;
  logic        w_addr_load;
  logic [3:0]  w_addr_pic;
  logic [1:0]  w_addr_burst;

  assign w_accept     = req_valid & req_ready;
  assign w_rd_hs      = (r_state == RD_R) & rvalid_s_inf & rd_ready;
  assign w_w_hs       = (r_state == WR_W) & wr_valid & wready_s_inf;
  assign w_b_hs       = (r_state == WR_B) & bvalid_s_inf;
  assign w_last_burst = (r_burst_cnt == LAST_BURST);

  // The address register is loaded on the same edge that enters RD_AR/WR_AW,
  // so araddr/awaddr are already stable in the first cycle the valid is high.
  assign w_next_burst = ((w_rd_hs & rlast_s_inf) | w_b_hs) & ~w_last_burst;
  assign w_addr_load  = w_accept | w_next_burst;
  assign w_addr_pic   = w_accept ? req_pic_no : r_pic_no;
  assign w_addr_burst = w_accept ? 2'd0 : (r_burst_cnt + 2'd1);

  isp_dram_addr_gen #(
    .BASE_ADDR      (BASE_ADDR),
    .PIC_BYTES      (PIC_BYTES),
    .BURSTS_PER_PIC (BURSTS_PER_PIC)
  ) u_addr_gen (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .i_load   (w_addr_load),
    .i_pic_no (w_addr_pic),
    .i_burst  (w_addr_burst),
    .o_addr   (r_addr)
  );

  // rlast ends a read burst regardless of the beat count; the beat counter
  // saturates at the last beat if the slave overruns.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= IDLE;
      r_pic_no    <= 4'd0;
      r_burst_cnt <= 2'd0;
      r_beat_cnt  <= 6'd0;
      r_err_acc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pic_no    <= req_pic_no;
            r_burst_cnt <= 2'd0;
            r_beat_cnt  <= 6'd0;
            r_err_acc   <= 1'b0;
            r_state     <= req_write ? WR_AW : RD_AR;
          end
        end
        RD_AR: begin
          if (arready_s_inf) begin
            r_state <= RD_R;
          end
        end
        RD_R: begin
          if (w_rd_hs) begin
            r_err_acc <= r_err_acc | (rresp_s_inf != 2'b00);
            if (rlast_s_inf) begin
              if (w_last_burst) begin
                r_state <= DONE;
              end else begin
                r_burst_cnt <= r_burst_cnt + 2'd1;
                r_beat_cnt  <= 6'd0;
                r_state     <= RD_AR;
              end
            end else if (r_beat_cnt != LAST_BEAT) begin
              r_beat_cnt <= r_beat_cnt + 6'd1;
            end
          end
        end
        WR_AW: begin
          if (awready_s_inf) begin
            r_state <= WR_W;
          end
        end
        WR_W: begin
          if (w_w_hs) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state <= WR_B;
            end else begin
              r_beat_cnt <= r_beat_cnt + 6'd1;
            end
          end
        end
        WR_B: begin
          if (w_b_hs) begin
            r_err_acc <= r_err_acc | (bresp_s_inf != 2'b00);
            if (w_last_burst) begin
              r_state <= DONE;
            end else begin
              r_burst_cnt <= r_burst_cnt + 2'd1;
              r_beat_cnt  <= 6'd0;
              r_state     <= WR_AW;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // req_ready is masked by reset so that every output reads 0 while reset is held.
  assign req_ready     = (r_state == IDLE) & ~rst_n;

  assign arid_s_inf    = AXI_ID;
  assign arlen_s_inf   = LEN_64;
  assign arsize_s_inf  = SIZE_16B;
  assign arburst_s_inf = BURST_INCR;
  assign araddr_s_inf  = r_addr;
  assign arvalid_s_inf = (r_state == RD_AR);

  assign rready_s_inf  = (r_state == RD_R) & rd_ready;
  assign rd_valid      = (r_state == RD_R) & rvalid_s_inf;
  assign rd_data       = (r_state == RD_R) ? rdata_s_inf : 128'd0;
  assign rd_idx        = {r_burst_cnt, r_beat_cnt};

  assign awid_s_inf    = AXI_ID;
  assign awlen_s_inf   = LEN_64;
  assign awsize_s_inf  = SIZE_16B;
  assign awburst_s_inf = BURST_INCR;
  assign awaddr_s_inf  = r_addr;
  assign awvalid_s_inf = (r_state == WR_AW);

  assign wr_req        = (r_state == WR_W);
  assign wr_idx        = {r_burst_cnt, r_beat_cnt};
  assign wvalid_s_inf  = (r_state == WR_W) & wr_valid;
  assign wdata_s_inf   = (r_state == WR_W) ? wr_data : 128'd0;
  assign wlast_s_inf   = (r_state == WR_W) & (r_beat_cnt == LAST_BEAT);

  assign bready_s_inf  = (r_state == WR_B);

  assign done          = (r_state == DONE);
  assign err           = (r_state == DONE) & r_err_acc;

endmodule

// File: tb/tb_isp_dram_ctrl.sv
// tb_isp_dram_ctrl: directed self-checking bench for isp_dram_ctrl.
// A behavioural pseudo_DRAM slave, an ISP read consumer and an ISP write producer
// run in one cycle loop: drive at the falling edge, observe handshakes 2 time units
// later, well before the next rising edge.
module tb_isp_dram_ctrl;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [3:0]   req_pic_no;
  logic         rd_valid;
  logic         rd_ready;
  logic [127:0] rd_data;
  logic [7:0]   rd_idx;
  logic         wr_req;
  logic         wr_valid;
  logic [127:0] wr_data;
  logic [7:0]   wr_idx;
  logic         done;
  logic         err;
  logic [3:0]   arid_s_inf;
  logic [31:0]  araddr_s_inf;
  logic [7:0]   arlen_s_inf;
  logic [2:0]   arsize_s_inf;
  logic [1:0]   arburst_s_inf;
  logic         arvalid_s_inf;
  logic         arready_s_inf;
  logic [127:0] rdata_s_inf;
  logic [1:0]   rresp_s_inf;
  logic         rlast_s_inf;
  logic         rvalid_s_inf;
  logic         rready_s_inf;
  logic [3:0]   awid_s_inf;
  logic [31:0]  awaddr_s_inf;
  logic [7:0]   awlen_s_inf;
  logic [2:0]   awsize_s_inf;
  logic [1:0]   awburst_s_inf;
  logic         awvalid_s_inf;
  logic         awready_s_inf;
  logic [127:0] wdata_s_inf;
  logic         wlast_s_inf;
  logic         wvalid_s_inf;
  logic         wready_s_inf;
  logic [1:0]   bresp_s_inf;
  logic         bvalid_s_inf;
  logic         bready_s_inf;

  isp_dram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_pic_no(req_pic_no),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_idx(rd_idx),
    .wr_req(wr_req), .wr_valid(wr_valid), .wr_data(wr_data), .wr_idx(wr_idx),
    .done(done), .err(err),
    .arid_s_inf(arid_s_inf), .araddr_s_inf(araddr_s_inf), .arlen_s_inf(arlen_s_inf),
    .arsize_s_inf(arsize_s_inf), .arburst_s_inf(arburst_s_inf),
    .arvalid_s_inf(arvalid_s_inf), .arready_s_inf(arready_s_inf),
    .rdata_s_inf(rdata_s_inf), .rresp_s_inf(rresp_s_inf), .rlast_s_inf(rlast_s_inf),
    .rvalid_s_inf(rvalid_s_inf), .rready_s_inf(rready_s_inf),
    .awid_s_inf(awid_s_inf), .awaddr_s_inf(awaddr_s_inf), .awlen_s_inf(awlen_s_inf),
    .awsize_s_inf(awsize_s_inf), .awburst_s_inf(awburst_s_inf),
    .awvalid_s_inf(awvalid_s_inf), .awready_s_inf(awready_s_inf),
    .wdata_s_inf(wdata_s_inf), .wlast_s_inf(wlast_s_inf),
    .wvalid_s_inf(wvalid_s_inf), .wready_s_inf(wready_s_inf),
    .bresp_s_inf(bresp_s_inf), .bvalid_s_inf(bvalid_s_inf), .bready_s_inf(bready_s_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  bit rdToggle = 0;
  bit wrGaps   = 0;
  bit slvStall = 0;
  int errBeat  = -1;
  int expPic   = 0;

  int rdBeats, rdBad, rreadyBad, arBad, awBad, wBad, wlastCnt, bCnt;
  int doneCnt, acceptCnt, acceptCycle, firstArCycle, lastRCycle, doneCycle;
  int slvBeat, wBurst;
  bit lastErr;
  logic [31:0] arLog[$];
  logic [31:0] awLog[$];

  bit          rdActive = 0;
  logic [31:0] rdAddr   = 32'd0;
  int          rdBeat   = 0;
  bit          awActive = 0;
  int          wBeat    = 0;
  bit          bPending = 0;

  function automatic logic [127:0] rdPattern(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0000_1234};
  endfunction

  function automatic logic [127:0] wrPattern(input logic [7:0] i);
    return {24'hDA7A00, i, 24'h000000, ~i, {4{i}}, 32'h1357_9BDF};
  endfunction

  function automatic logic [31:0] arAt(input int i);
    return (i < arLog.size()) ? arLog[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] awAt(input int i);
    return (i < awLog.size()) ? awLog[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearStats();
    rdBeats = 0; rdBad = 0; rreadyBad = 0; arBad = 0; awBad = 0; wBad = 0;
    wlastCnt = 0; bCnt = 0; doneCnt = 0; acceptCnt = 0; acceptCycle = -1;
    firstArCycle = -1; lastRCycle = -1; doneCycle = -1; slvBeat = 0; wBurst = 0;
    lastErr = 1'b0;
    arLog.delete();
    awLog.delete();
  endtask

  // Raises a request and holds it until the controller takes it.
  task automatic applyStimulus(input bit write, input int pic);
    bit taken = 0;
    expPic     = pic;
    req_write  = write;
    req_pic_no = 4'(pic);
    req_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (acceptCnt > 0) begin
        taken = 1;
        break;
      end
    end
    req_valid = 1'b0;
    if (!taken) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitDone(input string tag);
    bit seen = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (doneCnt > 0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done_pulses"}, 64'(doneCnt), 64'd1);
  endtask

  // Environment: pseudo_DRAM slave, read consumer and write producer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        rdActive = 0;
        awActive = 0;
        bPending = 0;
      end
      arready_s_inf = !rdActive && (slvStall ? ($urandom_range(0, 1) == 1) : 1'b1);
      rvalid_s_inf  = rdActive && (slvStall ? ($urandom_range(0, 1) == 1) : 1'b1);
      rdata_s_inf   = rdPattern(rdAddr + 32'(rdBeat * 16));
      rlast_s_inf   = rdActive && (rdBeat == 63);
      rresp_s_inf   = (rdActive && slvBeat == errBeat) ? 2'b10 : 2'b00;
      awready_s_inf = !awActive && !bPending && (slvStall ? ($urandom_range(0, 1) == 1) : 1'b1);
      wready_s_inf  = awActive && (slvStall ? ($urandom_range(0, 1) == 1) : 1'b1);
      bvalid_s_inf  = bPending && (slvStall ? ($urandom_range(0, 1) == 1) : 1'b1);
      bresp_s_inf   = 2'b00;
      rd_ready      = rdToggle ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      wr_valid = wr_req && (wrGaps ? ($urandom_range(0, 2) != 0) : 1'b1);
      wr_data  = wrPattern(wr_idx);
      #1;
      cyc++;
      if (!rst_n) begin
        if (req_valid && req_ready) begin
          acceptCnt++;
          acceptCycle = cyc;
        end
        if (arvalid_s_inf && firstArCycle < 0) firstArCycle = cyc;
        if (rready_s_inf && !rd_ready) rreadyBad++;
        if (rvalid_s_inf) begin
          if (rd_valid !== 1'b1 || rready_s_inf !== rd_ready) rreadyBad++;
          if (rready_s_inf) begin
            if (rd_idx !== 8'(rdBeats) ||
                rd_data !== rdPattern(32'h0001_0000 + 32'(expPic * 3072 + rdBeats * 16)))
              rdBad++;
            rdBeats++;
            slvBeat++;
            lastRCycle = cyc;
            if (rdBeat == 63) rdActive = 0;
            else rdBeat++;
          end
        end
        if (arvalid_s_inf && arready_s_inf) begin
          arLog.push_back(araddr_s_inf);
          if (arlen_s_inf !== 8'd63 || arsize_s_inf !== 3'b100 || arburst_s_inf !== 2'b01 ||
              arid_s_inf !== 4'd0 || araddr_s_inf[3:0] !== 4'd0 ||
              (int'(araddr_s_inf[11:0]) + 64 * 16) > 4096)
            arBad++;
          rdActive = 1;
          rdAddr   = araddr_s_inf;
          rdBeat   = 0;
        end
        if (wvalid_s_inf && (!awActive || !wr_valid)) wBad++;
        if (wvalid_s_inf && wready_s_inf) begin
          if (wdata_s_inf !== wrPattern(8'(wBurst * 64 + wBeat))) wBad++;
          if (wlast_s_inf !== (wBeat == 63)) wBad++;
          if (wlast_s_inf) wlastCnt++;
          wBeat++;
          if (wBeat == 64) begin
            awActive = 0;
            bPending = 1;
          end
        end
        if (awvalid_s_inf && awready_s_inf) begin
          awLog.push_back(awaddr_s_inf);
          if (awlen_s_inf !== 8'd63 || awsize_s_inf !== 3'b100 || awburst_s_inf !== 2'b01 ||
              awid_s_inf !== 4'd0)
            awBad++;
          awActive = 1;
          wBeat    = 0;
        end
        if (bvalid_s_inf && bready_s_inf) begin
          bCnt++;
          bPending = 0;
          wBurst++;
        end
        if (done) begin
          doneCnt++;
          lastErr   = err;
          doneCycle = cyc;
        end
      end
    end
  end

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_pic_no = 4'd0;
    rd_ready   = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 128'd0;
    clearStats();

    repeat (3) @(negedge clk);
    #3;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_valids", 64'({arvalid_s_inf, rready_s_inf, awvalid_s_inf, wvalid_s_inf,
                                   bready_s_inf, rd_valid, wr_req, done, err}), 64'd0);
    checkOutput("rst_idx_addr", {16'd0, rd_idx, wr_idx, araddr_s_inf}, 64'd0);
    checkOutput("const_attrs", 64'({arsize_s_inf, arburst_s_inf, arlen_s_inf, arid_s_inf,
                                    awsize_s_inf, awburst_s_inf, awlen_s_inf, awid_s_inf}),
                64'({3'b100, 2'b01, 8'd63, 4'd0, 3'b100, 2'b01, 8'd63, 4'd0}));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    checkOutput("idle_req_ready", 64'(req_ready), 64'd1);

    $display("[TB] read pic 0, zero-wait slave");
    @(negedge clk);
    clearStats();
    applyStimulus(1'b0, 0);
    waitDone("t1");
    checkOutput("t1_ar_count", 64'(arLog.size()), 64'd3);
    checkOutput("t1_ar0", 64'(arAt(0)), 64'h0001_0000);
    checkOutput("t1_ar1", 64'(arAt(1)), 64'h0001_0400);
    checkOutput("t1_ar2", 64'(arAt(2)), 64'h0001_0800);
    checkOutput("t1_ar_attr_bad", 64'(arBad), 64'd0);
    checkOutput("t1_beats", 64'(rdBeats), 64'd192);
    checkOutput("t1_data_bad", 64'(rdBad), 64'd0);
    checkOutput("t1_err", 64'(lastErr), 64'd0);
    checkOutput("t1_accept_to_ar", 64'(firstArCycle - acceptCycle), 64'd1);
    checkOutput("t1_rlast_to_done", 64'(doneCycle - lastRCycle), 64'd1);

    $display("[TB] read pic 15");
    clearStats();
    applyStimulus(1'b0, 15);
    waitDone("t2");
    checkOutput("t2_ar0", 64'(arAt(0)), 64'h0001_B400);
    checkOutput("t2_ar1", 64'(arAt(1)), 64'h0001_B800);
    checkOutput("t2_ar2", 64'(arAt(2)), 64'h0001_BC00);
    checkOutput("t2_ar_4k_bad", 64'(arBad), 64'd0);
    checkOutput("t2_data_bad", 64'(rdBad), 64'd0);

    $display("[TB] write pic 3, producer gaps, stalling slave");
    clearStats();
    wrGaps   = 1;
    slvStall = 1;
    applyStimulus(1'b1, 3);
    waitDone("t3");
    checkOutput("t3_aw_count", 64'(awLog.size()), 64'd3);
    checkOutput("t3_aw0", 64'(awAt(0)), 64'h0001_2400);
    checkOutput("t3_aw1", 64'(awAt(1)), 64'h0001_2800);
    checkOutput("t3_aw2", 64'(awAt(2)), 64'h0001_2C00);
    checkOutput("t3_aw_attr_bad", 64'(awBad), 64'd0);
    checkOutput("t3_w_bad", 64'(wBad), 64'd0);
    checkOutput("t3_wlast_count", 64'(wlastCnt), 64'd3);
    checkOutput("t3_b_count", 64'(bCnt), 64'd3);
    checkOutput("t3_no_reads", 64'(arLog.size()), 64'd0);
    checkOutput("t3_err", 64'(lastErr), 64'd0);
    wrGaps = 0;

    $display("[TB] read pic 5, rd_ready toggling, stray request while busy");
    clearStats();
    rdToggle = 1;
    applyStimulus(1'b0, 5);
    req_write  = 1'b1;
    req_pic_no = 4'd9;
    req_valid  = 1'b1;
    repeat (6) @(negedge clk);
    req_valid = 1'b0;
    waitDone("t4");
    checkOutput("t4_beats", 64'(rdBeats), 64'd192);
    checkOutput("t4_data_bad", 64'(rdBad), 64'd0);
    checkOutput("t4_rready_bad", 64'(rreadyBad), 64'd0);
    checkOutput("t4_accepts", 64'(acceptCnt), 64'd1);
    checkOutput("t4_no_writes", 64'(awLog.size()), 64'd0);
    checkOutput("t4_ar_count", 64'(arLog.size()), 64'd3);
    rdToggle = 0;
    slvStall = 0;

    $display("[TB] read pic 2 with rresp error on beat 100");
    clearStats();
    errBeat = 100;
    applyStimulus(1'b0, 2);
    waitDone("t5");
    checkOutput("t5_beats", 64'(rdBeats), 64'd192);
    checkOutput("t5_err", 64'(lastErr), 64'd1);
    errBeat = -1;
    clearStats();
    applyStimulus(1'b0, 2);
    waitDone("t5b");
    checkOutput("t5b_err", 64'(lastErr), 64'd0);
    checkOutput("t5b_data_bad", 64'(rdBad), 64'd0);

    $display("[TB] reset during read beat 40");
    clearStats();
    applyStimulus(1'b0, 7);
    begin
      bit reached = 0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (rdBeats >= 40) begin
          reached = 1;
          break;
        end
      end
      if (!reached) checkOutput("t6_beat40_timeout", 64'd0, 64'd1);
    end
    #3;
    rst_n = 1'b1;
    #1;
    checkOutput("t6_async_drop", 64'({arvalid_s_inf, rready_s_inf, awvalid_s_inf, wvalid_s_inf,
                                      bready_s_inf, rd_valid, wr_req, req_ready, done}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    checkOutput("t6_ready_after", 64'(req_ready), 64'd1);
    checkOutput("t6_idx_after", 64'({rd_idx, wr_idx}), 64'd0);
    @(negedge clk);
    clearStats();
    applyStimulus(1'b0, 1);
    waitDone("t6b");
    checkOutput("t6b_ar0", 64'(arAt(0)), 64'h0001_0C00);
    checkOutput("t6b_ar2", 64'(arAt(2)), 64'h0001_1400);
    checkOutput("t6b_beats", 64'(rdBeats), 64'd192);
    checkOutput("t6b_data_bad", 64'(rdBad), 64'd0);
    checkOutput("t6b_err", 64'(lastErr), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/isp_dram_ctrl.md
Name: isp_dram_ctrl

Overview:
- AXI4 master sequencer between the ISP core and pseudo_DRAM.
- Accepts one picture-level request at a time, either a read (fetch) or a write (write-back).
- Splits each 3072-byte picture (32x32x3 bytes, 192 beats of 128 bits) into three 64-beat INCR bursts, so no burst crosses a 4 KB boundary.
- Streams read beats to the ISP datapath, pulls write beats from it, and reports completion and AXI errors.

Parameters:
- BASE_ADDR, 32'h0001_0000, DRAM byte address of picture 0.
- PIC_BYTES, 3072, bytes per picture; fixed stride between pictures.
- BEATS_PER_BURST, 64, beats per AXI burst (awlen/arlen = BEATS_PER_BURST-1).
- BURSTS_PER_PIC, 3, bursts per picture.
- AXI_ID, 4'd0, constant ID on AR and AW.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-high (1 = reset)
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_write  in  1  0 = read picture, 1 = write picture
- req_pic_no  in  4  picture index 0..15
- rd_valid  out  1  read beat available (mirrors rvalid in RD_R)
- rd_ready  in  1  consumer accepts the read beat
- rd_data  out  128  read beat data (passes rdata through)
- rd_idx  out  8  beat index within picture, 0..191
- wr_req  out  1  asks the producer for the beat at wr_idx (high in WR_W)
- wr_valid  in  1  producer beat valid
- wr_data  in  128  producer beat
- wr_idx  out  8  beat index within picture, 0..191
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 if any rresp or bresp was nonzero during the request
- AXI master ports, widths as in ISP:
  - ar*_s_inf, r*_s_inf
  - aw*_s_inf, w*_s_inf, b*_s_inf

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, err_acc 0.
- Constant outputs:
  - arsize/awsize = 3'b100.
  - arburst/awburst = 2'b01.
  - arlen/awlen = 8'd63.
  - arid/awid = AXI_ID.
- Request accept: accepted when req_valid && req_ready.
  - Latches pic_no and dir.
  - Clears burst_cnt, beat_cnt and err_acc.
  - Next state RD_AR or WR_AW.
- Burst address: addr = BASE_ADDR + pic_no*PIC_BYTES + burst_cnt*1024.
  - Registered; computed with shift-add only (3072 = 2048 + 1024).
- States:
  - IDLE: req_ready = 1.
  - RD_AR: arvalid = 1 with a stable araddr until arready. On arready go to RD_R next cycle; arvalid deasserts the same edge.
  - RD_R: rready = rd_ready. On each rvalid && rready beat:
    - beat_cnt++ (rd_idx = burst_cnt*64 + beat_cnt);
    - err_acc |= (rresp != 0).
    - On rlast: if burst_cnt == 2 go to DONE; else burst_cnt++, beat_cnt = 0, go to RD_AR.
    - rlast is trusted over beat_cnt. If beat_cnt reaches 63 without rlast, keep accepting beats and do not count past 63.
  - WR_AW: awvalid = 1 until awready, then go to WR_W. No W beat is issued before the AW handshake.
  - WR_W: wr_req = 1.
    - wvalid = wr_valid; wdata = wr_data; wlast = (beat_cnt == 63).
    - On wvalid && wready: beat_cnt++. If it was the last beat, go to WR_B.
    - The producer may hold wr_valid low for any number of cycles; wvalid follows it.
  - WR_B: bready = 1.
    - On bvalid: err_acc |= (bresp != 0).
    - If burst_cnt == 2 go to DONE; else burst_cnt++, beat_cnt = 0, go to WR_AW.
  - DONE: done = 1 and err = err_acc for exactly one cycle, then IDLE.
- Total beats per request: 192 on rd_valid&&rd_ready or on W. rd_idx/wr_idx cover 0..191 with no gaps.
- req_valid outside IDLE is ignored (not queued).
- Reset mid-burst: immediate return to IDLE, all valids and readies drop asynchronously. The DRAM-side burst is abandoned; after reset the slave is assumed reset too.
- Simultaneous rvalid and rlast on the beat that also carries an error: the error is captured before the state change.
- Latency, read: request accept to arvalid is 1 cycle; DONE follows 1 cycle after the final rlast beat.

Decomposition:
- Package isp_dram_pkg holds:
  - the state enum (IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, DONE);
  - AXI constants: SIZE_16B, BURST_INCR, LEN_64;
  - PIC_BYTES and BASE_ADDR.
- One sub-module, isp_dram_addr_gen: registered address from pic_no and burst_cnt.
- The FSM and counters stay in the top module.

Test Plan:
- Read pic 0, zero-wait slave, rd_ready = 1:
  - three AR at 0x10000, 0x10400, 0x10800, each arlen = 63;
  - 192 beats with rd_idx 0..191;
  - done pulses, err = 0.
- Read pic 15:
  - araddr 0x1B400, 0x1B800, 0x1BC00;
  - no burst crosses a 4 KB boundary (assertion on every AR).
- Write pic 3 with random wr_valid gaps and a slave that stalls wready and awready:
  - AW at 0x12400, 0x12800, 0x12C00;
  - wlast on wr_idx 63, 127, 191 only;
  - three B handshakes, then done.
- Read with rd_ready toggling 50%:
  - rready tracks rd_ready;
  - data order preserved;
  - beat count is exactly 192.
- Slave returns rresp = 2'b10 on beat 100:
  - transfer completes all 192 beats;
  - done with err = 1;
  - the next clean request reports err = 0.
- Assert rst_n during RD_R beat 40:
  - all valids and readies are 0 the same cycle;
  - state IDLE, req_ready = 1 after release;
  - a new read of pic 1 completes normally.
